// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU operand stage: operation encoding,
// forward-source selection and datapath widths.
package alu_pkg;

    localparam int N_DEF  = 32;
    localparam int RA_DEF = 5;
    localparam int IMM_W  = 16;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_XOR = 4'd2,
        ALU_NOR = 4'd3,
        ALU_ADD = 4'd4,
        ALU_SUB = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Bypass selector for one source operand: the youngest in-flight producer
// (EX/MEM) wins over MEM/WB, which wins over the register file; r0 never forwards.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RA = RA_DEF
) (
    input  logic [RA-1:0] i_src_addr,
    input  logic [N-1:0]  i_rf_data,
    input  logic          i_exm_we,
    input  logic [RA-1:0] i_exm_addr,
    input  logic [N-1:0]  i_exm_data,
    input  logic          i_mwb_we,
    input  logic [RA-1:0] i_mwb_addr,
    input  logic [N-1:0]  i_mwb_data,
    output logic [N-1:0]  o_fwd_data
);

    logic     w_src_nz;
    logic     w_exm_hit;
    logic     w_mwb_hit;
    fwd_sel_t w_sel;

    assign w_src_nz  = (i_src_addr != {RA{1'b0}});
    assign w_exm_hit = i_exm_we && (i_exm_addr == i_src_addr) && w_src_nz;
    assign w_mwb_hit = i_mwb_we && (i_mwb_addr == i_src_addr) && w_src_nz;

    // Priority encode the source of the operand.
    always_comb begin
        w_sel = FWD_RF;
        if (w_exm_hit) begin
            w_sel = FWD_EXM;
        end else if (w_mwb_hit) begin
            w_sel = FWD_MWB;
        end else begin
            w_sel = FWD_RF;
        end
    end

    // Steer the selected source onto the operand.
    always_comb begin
        o_fwd_data = i_rf_data;
        case (w_sel)
            FWD_EXM: o_fwd_data = i_exm_data;
            FWD_MWB: o_fwd_data = i_mwb_data;
            FWD_RF:  o_fwd_data = i_rf_data;
            default: o_fwd_data = i_rf_data;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: immediate extension, operand bypass and a
// valid/ready output slot. Define ALU_OPSTAGE_FWD_EN to enable forwarding/snoop.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RA = RA_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_rs_data,
    input  logic [N-1:0]  in_rt_data,
    input  logic [RA-1:0] in_rs_addr,
    input  logic [RA-1:0] in_rt_addr,
    input  logic [RA-1:0] in_wr_addr,
    input  logic          in_reg_write,
    input  logic [15:0]   in_imm,
    input  logic          in_use_imm,
    input  logic          in_sign_ext,
    input  logic [3:0]    in_alu_op,
    input  logic          exm_we,
    input  logic [RA-1:0] exm_addr,
    input  logic [N-1:0]  exm_data,
    input  logic          mwb_we,
    input  logic [RA-1:0] mwb_addr,
    input  logic [N-1:0]  mwb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_a,
    output logic [N-1:0]  out_b,
    output logic [3:0]    out_alu_op,
    output logic [RA-1:0] out_wr_addr,
    output logic          out_reg_write
);

    function automatic logic [N-1:0] ext_imm(input logic [IMM_W-1:0] imm, input logic sext);
        ext_imm = {{(N-IMM_W){sext & imm[IMM_W-1]}}, imm};
    endfunction

    logic          r_valid;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    alu_op_t       r_alu_op;
    logic [RA-1:0] r_wr_addr;
    logic          r_reg_write;
    logic [RA-1:0] r_rs_addr;
    logic [RA-1:0] r_rt_addr;
    logic          r_use_imm;

    logic          w_exm_we;
    logic          w_mwb_we;
    logic [N-1:0]  w_rs_fwd;
    logic [N-1:0]  w_rt_fwd;
    logic [N-1:0]  w_b_next;
    logic          w_capture;
    logic          w_load;
    logic          w_held;
    logic          w_snoop_a;
    logic          w_snoop_b;

`ifdef ALU_OPSTAGE_FWD_EN
    assign w_exm_we = exm_we;
    assign w_mwb_we = mwb_we;
`else
    // With bypassing compiled out, write enables are forced low so every
    // hit compare folds away; the raw enables are deliberately unused.
    logic w_unused_we;
    assign w_exm_we    = 1'b0;
    assign w_mwb_we    = 1'b0;
    assign w_unused_we = exm_we ^ mwb_we;
`endif

    fwd_mux #(.N(N), .RA(RA)) u_fwd_rs (
        .i_src_addr (in_rs_addr),
        .i_rf_data  (in_rs_data),
        .i_exm_we   (w_exm_we),
        .i_exm_addr (exm_addr),
        .i_exm_data (exm_data),
        .i_mwb_we   (w_mwb_we),
        .i_mwb_addr (mwb_addr),
        .i_mwb_data (mwb_data),
        .o_fwd_data (w_rs_fwd)
    );

    fwd_mux #(.N(N), .RA(RA)) u_fwd_rt (
        .i_src_addr (in_rt_addr),
        .i_rf_data  (in_rt_data),
        .i_exm_we   (w_exm_we),
        .i_exm_addr (exm_addr),
        .i_exm_data (exm_data),
        .i_mwb_we   (w_mwb_we),
        .i_mwb_addr (mwb_addr),
        .i_mwb_data (mwb_data),
        .o_fwd_data (w_rt_fwd)
    );

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready;
    assign w_load    = w_capture && !flush;
    assign w_b_next  = in_use_imm ? ext_imm(in_imm, in_sign_ext) : w_rt_fwd;
    assign w_held    = r_valid && !out_ready;

    // A producer retiring from MEM/WB while we stall would otherwise be lost;
    // EX/MEM is not watched because its result may still change.
    assign w_snoop_a = w_held && w_mwb_we && (mwb_addr == r_rs_addr) && (r_rs_addr != {RA{1'b0}});
    assign w_snoop_b = w_held && w_mwb_we && (mwb_addr == r_rt_addr) && (r_rt_addr != {RA{1'b0}})
                       && !r_use_imm;

    // Slot occupancy: flush wins over capture, consumption empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Payload: load on accepted capture, otherwise hold with operand snoop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= {N{1'b0}};
            r_b         <= {N{1'b0}};
            r_alu_op    <= ALU_AND;
            r_wr_addr   <= {RA{1'b0}};
            r_reg_write <= 1'b0;
            r_rs_addr   <= {RA{1'b0}};
            r_rt_addr   <= {RA{1'b0}};
            r_use_imm   <= 1'b0;
        end else if (w_load) begin
            r_a         <= w_rs_fwd;
            r_b         <= w_b_next;
            r_alu_op    <= alu_op_t'(in_alu_op);
            r_wr_addr   <= in_wr_addr;
            r_reg_write <= in_reg_write;
            r_rs_addr   <= in_rs_addr;
            r_rt_addr   <= in_rt_addr;
            r_use_imm   <= in_use_imm;
        end else begin
            r_a <= w_snoop_a ? mwb_data : r_a;
            r_b <= w_snoop_b ? mwb_data : r_b;
        end
    end

    assign out_valid     = r_valid;
    assign out_a         = r_a;
    assign out_b         = r_b;
    assign out_alu_op    = r_alu_op;
    assign out_wr_addr   = r_wr_addr;
    assign out_reg_write = r_reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed by
// random traffic against a transaction-level reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [4:0]  in_rs_addr;
    logic [4:0]  in_rt_addr;
    logic [4:0]  in_wr_addr;
    logic        in_reg_write;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic        in_sign_ext;
    logic [3:0]  in_alu_op;
    logic        exm_we;
    logic [4:0]  exm_addr;
    logic [31:0] exm_data;
    logic        mwb_we;
    logic [4:0]  mwb_addr;
    logic [31:0] mwb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_wr_addr;
    logic        out_reg_write;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_wr_addr(in_wr_addr), .in_reg_write(in_reg_write),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext),
        .in_alu_op(in_alu_op),
        .exm_we(exm_we), .exm_addr(exm_addr), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_addr(mwb_addr), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
        .out_wr_addr(out_wr_addr), .out_reg_write(out_reg_write)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the instruction currently presented to the ALU.
    logic        m_valid = 1'b0;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_wr, m_rs, m_rt;
    logic        m_rw, m_imm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf);
`ifdef ALU_OPSTAGE_FWD_EN
        if (src != 5'd0 && exm_we && exm_addr == src) return exm_data;
        if (src != 5'd0 && mwb_we && mwb_addr == src) return mwb_data;
`endif
        return rf;
    endfunction

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs_data = 32'd0; in_rt_data = 32'd0; in_rs_addr = 5'd0; in_rt_addr = 5'd0;
        in_wr_addr = 5'd0; in_reg_write = 1'b0; in_imm = 16'd0; in_use_imm = 1'b0;
        in_sign_ext = 1'b0; in_alu_op = 4'd0;
        exm_we = 1'b0; exm_addr = 5'd0; exm_data = 32'd0;
        mwb_we = 1'b0; mwb_addr = 5'd0; mwb_data = 32'd0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                         input logic [31:0] rtd, input logic [15:0] imm, input logic use_imm,
                         input logic sext, input logic [3:0] op, input logic [4:0] wr);
        in_valid = 1'b1; in_rs_addr = rs; in_rs_data = rsd; in_rt_addr = rt; in_rt_data = rtd;
        in_imm = imm; in_use_imm = use_imm; in_sign_ext = sext; in_alu_op = op;
        in_wr_addr = wr; in_reg_write = (wr != 5'd0);
    endtask

    // One clock: predict the presented instruction, clock, compare.
    task automatic tick();
        logic accept;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        accept = in_valid && (!m_valid || out_ready);
        if (flush) begin
            m_valid = 1'b0;
        end else if (accept) begin
            m_valid = 1'b1;
            m_a  = operand(in_rs_addr, in_rs_data);
            m_b  = !in_use_imm ? operand(in_rt_addr, in_rt_data)
                 : in_sign_ext ? 32'($signed(in_imm)) : 32'(in_imm);
            m_op = in_alu_op; m_wr = in_wr_addr; m_rw = in_reg_write;
            m_rs = in_rs_addr; m_rt = in_rt_addr; m_imm = in_use_imm;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
`ifdef ALU_OPSTAGE_FWD_EN
            if (mwb_we && m_rs != 5'd0 && mwb_addr == m_rs) m_a = mwb_data;
            if (mwb_we && !m_imm && m_rt != 5'd0 && mwb_addr == m_rt) m_b = mwb_data;
`endif
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("out_a", out_a, m_a);
            check("out_b", out_b, m_b);
            check("out_alu_op", {28'd0, out_alu_op}, {28'd0, m_op});
            check("out_wr_addr", {27'd0, out_wr_addr}, {27'd0, m_wr});
            check("out_reg_write", {31'd0, out_reg_write}, {31'd0, m_rw});
        end
    endtask

    initial begin
        int beats;
        rst_n = 1'b0;
        idle();
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_a", out_a, 32'd0);
        check("rst_b", out_b, 32'd0);
        check("rst_op", {28'd0, out_alu_op}, 32'd0);
        check("rst_wr", {27'd0, out_wr_addr}, 32'd0);
        check("rst_rw", {31'd0, out_reg_write}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain capture
        instr(5'd5, 32'h0F0F_0F0F, 5'd6, 32'h00FF_00FF, 16'd0, 1'b0, 1'b0, 4'd0, 5'd9);
        tick();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_a", out_a, 32'h0F0F_0F0F);
        check("t1_b", out_b, 32'h00FF_00FF);

        // Immediate extension
        instr(5'd1, 32'd1, 5'd2, 32'd2, 16'h8001, 1'b1, 1'b1, 4'd4, 5'd3);
        tick();
        check("t2_sext", out_b, 32'hFFFF_8001);
        in_sign_ext = 1'b0;
        tick();
        check("t2_zext", out_b, 32'h0000_8001);

        // Forward priority and r0
        instr(5'd3, 32'h1111_1111, 5'd4, 32'd4, 16'd0, 1'b0, 1'b0, 4'd1, 5'd8);
        exm_we = 1'b1; exm_addr = 5'd3; exm_data = 32'hAAAA_AAAA;
        mwb_we = 1'b1; mwb_addr = 5'd3; mwb_data = 32'h5555_5555;
        tick();
`ifdef ALU_OPSTAGE_FWD_EN
        check("t3_exm_wins", out_a, 32'hAAAA_AAAA);
`else
        check("t3_no_fwd", out_a, 32'h1111_1111);
`endif
        in_rs_addr = 5'd0; in_rs_data = 32'h2222_2222; exm_addr = 5'd0; mwb_addr = 5'd0;
        tick();
        check("t3_r0", out_a, 32'h2222_2222);
        exm_we = 1'b0; mwb_we = 1'b0;

        // Stall with snoop of a retiring producer
        instr(5'd2, 32'd7, 5'd7, 32'hDEAD_BEEF, 16'd0, 1'b0, 1'b0, 4'd2, 5'd10);
        tick();
        instr(5'd11, 32'h9999_9999, 5'd12, 32'h8888_8888, 16'd0, 1'b0, 1'b0, 4'd5, 5'd13);
        out_ready = 1'b0;
        mwb_we = 1'b1; mwb_addr = 5'd7; mwb_data = 32'h1234_5678;
        tick();
        check("t4_stall_rdy1", {31'd0, in_ready}, 32'd0);
        mwb_we = 1'b0;
        tick();
        check("t4_stall_rdy2", {31'd0, in_ready}, 32'd0);
        tick();
        check("t4_stall_rdy3", {31'd0, in_ready}, 32'd0);
`ifdef ALU_OPSTAGE_FWD_EN
        check("t4_snoop", out_b, 32'h1234_5678);
`else
        check("t4_nosnoop", out_b, 32'hDEAD_BEEF);
`endif
        check("t4_a_hold", out_a, 32'd7);

        // Flush during stall, then flush against an accepted capture
        flush = 1'b1;
        tick();
        check("t5_flush", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("t5_not_presented", {31'd0, out_valid}, 32'd0);
        instr(5'd4, 32'h4444_4444, 5'd5, 32'd5, 16'd0, 1'b0, 1'b0, 4'd6, 5'd14);
        flush = 1'b1;
        tick();
        check("t5_flush_capture", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;

        // Back-to-back beats
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            instr(5'd6, 32'h100 + 32'(i), 5'd7, 32'h200 + 32'(i), 16'd0, 1'b0, 1'b0, 4'd4, 5'd15);
            tick();
            if (out_valid) beats++;
        end
        check("t6_beats", 32'(beats), 32'd4);
        in_valid = 1'b0;
        tick();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            instr(5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                  16'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
                  5'($urandom));
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            exm_we = 1'($urandom); exm_addr = 5'($urandom_range(0, 7)); exm_data = $urandom;
            mwb_we = 1'($urandom); mwb_addr = 5'($urandom_range(0, 7)); mwb_data = $urandom;
            tick();
        end

        // Async reset while an instruction is held
        idle();
        instr(5'd1, 32'hCAFE_0001, 5'd2, 32'hCAFE_0002, 16'd0, 1'b0, 1'b0, 4'd3, 5'd4);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_a", out_a, 32'd0);
        check("arst_rw", {31'd0, out_reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle();
        tick();
        check("arst_after", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
